// File: rtl/ram_upload_source.sv
// Streams a window of game RAM to the data_io upload path, one byte per host
// read strobe, always holding the next byte pre-fetched in ioctl_din.
module ram_upload_source #(
  parameter int         AW    = 10,
  parameter int         LEN   = 1024,
  parameter int         BASE  = 0,
  parameter logic [7:0] INDEX = 8'h03
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  output logic [7:0]    ioctl_din,
  output logic          ram_req,
  input  logic          ram_gnt,
  output logic [AW-1:0] ram_addr,
  input  logic [7:0]    ram_q,
  output logic          busy,
  output logic          underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_READY,
    S_DONE
  } state_t;

  localparam logic [AW:0]   LEN_C  = (AW+1)'(LEN);
  localparam logic [AW-1:0] BASE_C = AW'(BASE);

  state_t        r_state;
  logic [AW:0]   r_cnt;
  logic [7:0]    r_din;
  logic          r_req;
  logic [AW-1:0] r_addr;
  logic          r_und;
  logic          r_sess_d;

  state_t        w_state_nxt;
  logic [AW:0]   w_cnt_nxt;
  logic [AW:0]   w_cnt_inc;
  logic [7:0]    w_din_nxt;
  logic          w_und_nxt;
  logic          w_sess;
  logic          w_start;

  assign w_sess    = ioctl_upload && (ioctl_index == INDEX);
  assign w_start   = w_sess && !r_sess_d;
  assign w_cnt_inc = r_cnt + (AW+1)'(1);

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_din_nxt   = r_din;
    w_und_nxt   = r_und;

    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_cnt_nxt   = '0;
          w_und_nxt   = 1'b0;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (ioctl_rd) w_und_nxt = 1'b1;
        if (ram_gnt)  w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (ioctl_rd) w_und_nxt = 1'b1;
        w_din_nxt   = ram_q;
        w_state_nxt = S_READY;
      end
      S_READY: begin
        if (ioctl_rd) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == LEN_C) begin
            w_din_nxt   = 8'hFF;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_DONE: begin
        w_din_nxt = 8'hFF;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Session end wins over everything, including a same-cycle grant whose
    // returning data is then simply never captured.
    if (r_state != S_IDLE && !w_sess) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_din_nxt   = 8'h00;
    end
  end

  always_ff @(posedge clk_sys) begin
    // NOTE: state registers use non-blocking assignment so every flop sees pre-edge values.
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_din    <= 8'h00;
      r_req    <= 1'b0;
      r_addr   <= BASE_C;
      r_und    <= 1'b0;
      // A session already open across reset must fall and rise again to start.
      r_sess_d <= w_sess;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_din    <= w_din_nxt;
      r_req    <= (w_state_nxt == S_REQ);
      r_addr   <= BASE_C + w_cnt_nxt[AW-1:0];
      r_und    <= w_und_nxt;
      r_sess_d <= w_sess;
    end
  end

  assign ioctl_din = r_din;
  assign ram_req   = r_req;
  assign ram_addr  = r_addr;
  assign underrun  = r_und;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram_upload_source.sv
// Directed bench for ram_upload_source: a cycle table for a full 4-byte
// stream plus hand sequences for stall, underrun, wrong index, abort, reset.
module tb_ram_upload_source;

  localparam int AW = 10;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          ioctl_upload;
  logic [7:0]    ioctl_index;
  logic          ioctl_rd;
  logic [7:0]    ioctl_din;
  logic          ram_req;
  logic          ram_gnt;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_q;
  logic          busy;
  logic          underrun;

  logic [7:0] mem [0:1023];

  int n_cmp = 0;
  int n_bad = 0;

  ram_upload_source #(
    .AW   (AW),
    .LEN  (4),
    .BASE (32'h10),
    .INDEX(8'h03)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ioctl_upload(ioctl_upload),
    .ioctl_index (ioctl_index),
    .ioctl_rd    (ioctl_rd),
    .ioctl_din   (ioctl_din),
    .ram_req     (ram_req),
    .ram_gnt     (ram_gnt),
    .ram_addr    (ram_addr),
    .ram_q       (ram_q),
    .busy        (busy),
    .underrun    (underrun)
  );

  always #5 clk_sys = ~clk_sys;

  // Shared RAM read port: data for a granted address appears one cycle later.
  always @(posedge clk_sys) begin
    if (ram_req && ram_gnt) ram_q <= mem[ram_addr];
  end

  typedef struct {
    logic          up;
    logic [7:0]    idx;
    logic          rd;
    logic          gnt;
    logic          busy;
    logic          req;
    logic [AW-1:0] addr;
    logic [7:0]    din;
    logic          und;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic up, input logic rd, input logic b,
                              input logic rq, input logic [AW-1:0] a,
                              input logic [7:0] d, input logic u);
    vec_t v;
    v.up = up; v.idx = 8'h03; v.rd = rd; v.gnt = 1'b1;
    v.busy = b; v.req = rq; v.addr = a; v.din = d; v.und = u;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // {busy, ram_req, ram_addr, ioctl_din, underrun}
  function automatic logic [63:0] obs();
    return 64'({busy, ram_req, ram_addr, ioctl_din, underrun});
  endfunction

  function automatic logic [63:0] pk(input logic b, input logic rq, input logic [AW-1:0] a,
                                     input logic [7:0] d, input logic u);
    return 64'({b, rq, a, d, u});
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  logic [7:0] seen [$];
  logic [7:0] prev;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;
    mem[16] = 8'hA1; mem[17] = 8'hB2; mem[18] = 8'hC3; mem[19] = 8'hD4;

    //                 up rd busy req addr     din    und
    tbl[0]  = mk(1, 0, 1, 1, 10'h010, 8'h00, 0);
    tbl[1]  = mk(1, 0, 1, 0, 10'h010, 8'h00, 0);
    tbl[2]  = mk(1, 0, 1, 0, 10'h010, 8'hA1, 0);
    tbl[3]  = mk(1, 0, 1, 0, 10'h010, 8'hA1, 0);
    tbl[4]  = mk(1, 1, 1, 1, 10'h011, 8'hA1, 0);
    tbl[5]  = mk(1, 0, 1, 0, 10'h011, 8'hA1, 0);
    tbl[6]  = mk(1, 0, 1, 0, 10'h011, 8'hB2, 0);
    tbl[7]  = mk(1, 1, 1, 1, 10'h012, 8'hB2, 0);
    tbl[8]  = mk(1, 0, 1, 0, 10'h012, 8'hB2, 0);
    tbl[9]  = mk(1, 0, 1, 0, 10'h012, 8'hC3, 0);
    tbl[10] = mk(1, 1, 1, 1, 10'h013, 8'hC3, 0);
    tbl[11] = mk(1, 0, 1, 0, 10'h013, 8'hC3, 0);
    tbl[12] = mk(1, 0, 1, 0, 10'h013, 8'hD4, 0);
    tbl[13] = mk(1, 1, 1, 0, 10'h014, 8'hFF, 0);
    tbl[14] = mk(1, 1, 1, 0, 10'h014, 8'hFF, 0);
    tbl[15] = mk(1, 0, 1, 0, 10'h014, 8'hFF, 0);
    tbl[16] = mk(0, 0, 0, 0, 10'h010, 8'h00, 0);

    reset_n = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'h00;
    ioctl_rd = 1'b0; ram_gnt = 1'b0;
    step(); step();
    check("reset_state", obs(), pk(0, 0, 10'h010, 8'h00, 0));
    reset_n = 1'b1;
    step();

    // Basic stream, cycle-exact.
    for (int i = 0; i < 17; i++) begin
      ioctl_upload = tbl[i].up; ioctl_index = tbl[i].idx;
      ioctl_rd = tbl[i].rd; ram_gnt = tbl[i].gnt;
      step();
      check($sformatf("stream_row%0d", i), obs(),
            pk(tbl[i].busy, tbl[i].req, tbl[i].addr, tbl[i].din, tbl[i].und));
    end

    // Grant stall: request and address must hold until the grant.
    ram_gnt = 1'b0; ioctl_upload = 1'b1; ioctl_index = 8'h03; ioctl_rd = 1'b0;
    step();
    check("stall_req_entry", 64'({ram_req, ram_addr}), 64'({1'b1, 10'h010}));
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("stall_hold%0d", i), 64'({ram_req, ram_addr}), 64'({1'b1, 10'h010}));
    end
    ram_gnt = 1'b1;
    step();
    check("stall_wait", 64'({ram_req, ioctl_din}), 64'({1'b0, 8'h00}));
    step();
    check("stall_din", 64'(ioctl_din), 64'(8'hA1));
    ioctl_upload = 1'b0;
    step();

    // Underrun: strobes every other cycle, stream must not skip bytes.
    ioctl_upload = 1'b1;
    step();
    prev = ioctl_din;
    for (int i = 0; i < 30; i++) begin
      ioctl_rd = (i % 2 == 0);
      step();
      if (ioctl_din != prev) seen.push_back(ioctl_din);
      prev = ioctl_din;
    end
    ioctl_rd = 1'b0;
    check("underrun_set", 64'(underrun), 64'(1'b1));
    check("underrun_nbytes", 64'(seen.size()), 64'(5));
    if (seen.size() == 5)
      check("underrun_seq", 64'({seen[0], seen[1], seen[2], seen[3], seen[4]}),
            64'({8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hFF}));
    ioctl_upload = 1'b0;
    step();

    // Wrong index: block stays idle.
    ioctl_upload = 1'b1; ioctl_index = 8'h00;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("wrong_idx%0d", i), 64'({busy, ram_req, ram_addr, ioctl_din}),
            64'({1'b0, 1'b0, 10'h010, 8'h00}));
    end
    ioctl_upload = 1'b0; ioctl_index = 8'h03;
    step();

    // Abort after two bytes (end coincides with a grant), then restart.
    ioctl_upload = 1'b1;
    step();
    check("abort_start", obs(), pk(1, 1, 10'h010, 8'h00, 0));
    step(); step();
    check("abort_b0", 64'(ioctl_din), 64'(8'hA1));
    ioctl_rd = 1'b1; step(); ioctl_rd = 1'b0;
    step(); step();
    check("abort_b1", 64'(ioctl_din), 64'(8'hB2));
    ioctl_rd = 1'b1; step(); ioctl_rd = 1'b0;
    check("abort_req2", 64'({ram_req, ram_addr}), 64'({1'b1, 10'h012}));
    ioctl_upload = 1'b0;
    step();
    check("abort_idle", 64'({busy, ram_req, ram_addr, ioctl_din}), 64'({1'b0, 1'b0, 10'h010, 8'h00}));
    step();
    check("abort_discard", 64'(ioctl_din), 64'(8'h00));
    ioctl_upload = 1'b1;
    step();
    check("restart_req", obs(), pk(1, 1, 10'h010, 8'h00, 0));
    step(); step();
    check("restart_b0", 64'(ioctl_din), 64'(8'hA1));

    // Reset while in WAIT, with the session held high across it.
    ioctl_upload = 1'b0; step();
    ioctl_upload = 1'b1; step();
    step();
    check("pre_reset_wait", 64'({busy, ram_req}), 64'({1'b1, 1'b0}));
    reset_n = 1'b0;
    step();
    check("reset_mid", obs(), pk(0, 0, 10'h010, 8'h00, 0));
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("post_reset_idle%0d", i), 64'({busy, ram_req, ioctl_din}), 64'({1'b0, 1'b0, 8'h00}));
    end
    ioctl_upload = 1'b0; step();
    ioctl_upload = 1'b1; step();
    check("reraise_start", 64'({busy, ram_req, ram_addr}), 64'({1'b1, 1'b1, 10'h010}));
    ioctl_upload = 1'b0; step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
